ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 8'hED set-LEDs, 8'hFF reset) to the keyboard.
//  It is the counterpart of the keyboard receiver and shares the same PS2_CLK/PS2_DAT pins.
//  It drives both lines open-drain via output-enables (oe=1 pulls low) and releases both lines when idle.
//  The top level holds the receiver's read path off while busy=1.

---
 rtl/ps2_defs.sv | 29 ++
 rtl/ps2_line_filter.sv | 51 +++++
 rtl/ps2_host_tx.sv | 192 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: FSM state encodings, frame length, command codes
// and small helpers used by the host transmitter and the keyboard receiver.
package ps2_defs;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_INHIBIT   = 3'd1;
  localparam state_t ST_REQ       = 3'd2;
  localparam state_t ST_XFER      = 3'd3;
  localparam state_t ST_WAIT_IDLE = 3'd4;

  localparam int unsigned PS2_FRAME_EDGES = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // PS/2 uses odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchroniser, FILTER_LEN-sample glitch filter
// and registered fall/rise strobes of the filtered level.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_line,
  output logic o_sync,
  output logic o_level,
  output logic o_fall,
  output logic o_rise
);

  logic                  r_meta;
  logic                  r_sync;
  logic [FILTER_LEN-1:0] r_hist;
  logic                  r_level;
  logic                  r_fall;
  logic                  r_rise;
  logic                  w_all0;
  logic                  w_all1;

  assign w_all0 = (r_hist == {FILTER_LEN{1'b0}});
  assign w_all1 = (r_hist == {FILTER_LEN{1'b1}});

  // Idle bus level is high, so everything resets to 1 and no strobe fires at reset release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_hist  <= {FILTER_LEN{1'b1}};
      r_level <= 1'b1;
      r_fall  <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_meta  <= i_line;
      r_sync  <= r_meta;
      r_hist  <= {r_hist[FILTER_LEN-2:0], r_sync};
      r_level <= w_all1 ? 1'b1 : (w_all0 ? 1'b0 : r_level);
      r_fall  <= r_level & w_all0;
      r_rise  <= ~r_level & w_all1;
    end
  end

  assign o_sync  = r_sync;
  assign o_level = r_level;
  assign o_fall  = r_fall;
  assign o_rise  = r_rise;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// shifts out one command byte on device clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_defs::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned SETUP_CYCLES   = 50,
  parameter int unsigned TIMEOUT_START  = 750000,
  parameter int unsigned TIMEOUT_FRAME  = 100000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_send_valid,
  input  logic [7:0] i_send_data,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack_err,
  output logic       o_timeout,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_dat_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_dat_oe
);

  localparam int unsigned CNT_MAX = max2(max2(INHIBIT_CYCLES, SETUP_CYCLES),
                                         max2(TIMEOUT_START, TIMEOUT_FRAME));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t       INHIBIT_LAST = cnt_t'(INHIBIT_CYCLES - 1);
  localparam cnt_t       SETUP_LAST   = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t       START_LAST   = cnt_t'(TIMEOUT_START - 1);
  localparam cnt_t       FRAME_LAST   = cnt_t'(TIMEOUT_FRAME - 1);
  localparam logic [3:0] LAST_EDGE    = 4'(PS2_FRAME_EDGES - 1);

  state_t     r_state;
  cnt_t       r_cnt;
  logic [3:0] r_edge_cnt;
  logic [8:0] r_frame;
  logic       r_ack_lat;
  logic       r_dat_meta;
  logic       r_dat_sync;
  logic       r_clk_oe;
  logic       r_dat_oe;
  logic       r_ready;
  logic       r_busy;
  logic       r_done;
  logic       r_ack_err;
  logic       r_timeout;

  state_t     w_state_nxt;
  logic       w_timeout;
  logic       w_done;
  logic       w_clk_oe_nxt;
  logic       w_dat_oe_nxt;
  logic       w_xfer_expired;
  logic [3:0] w_edge_inc;
  logic       w_clk_sync;
  logic       w_clk_level;
  logic       w_fall;
  logic       w_clk_rise;
  logic       w_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .i_clk   (i_clock),
    .i_rst   (i_reset),
    .i_line  (i_ps2_clk_in),
    .o_sync  (w_clk_sync),
    .o_level (w_clk_level),
    .o_fall  (w_fall),
    .o_rise  (w_clk_rise)
  );

  assign w_unused   = w_clk_sync ^ w_clk_rise;
  assign w_edge_inc = r_edge_cnt + 4'd1;
  // Before the first fall the device gets the long start window; afterwards the frame window.
  assign w_xfer_expired = (r_edge_cnt == 4'd0) ? (r_cnt == START_LAST) : (r_cnt == FRAME_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_send_valid) w_state_nxt = ST_INHIBIT;
        else              w_state_nxt = ST_IDLE;
      end
      ST_INHIBIT: begin
        if (r_cnt == INHIBIT_LAST) w_state_nxt = ST_REQ;
        else                       w_state_nxt = ST_INHIBIT;
      end
      ST_REQ: begin
        if (r_cnt == SETUP_LAST) w_state_nxt = ST_XFER;
        else                     w_state_nxt = ST_REQ;
      end
      ST_XFER: begin
        if (w_fall) begin
          if (r_edge_cnt == LAST_EDGE) w_state_nxt = ST_WAIT_IDLE;
          else                         w_state_nxt = ST_XFER;
        end else if (w_xfer_expired) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = ST_XFER;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_clk_level && r_dat_sync) begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end else if (r_cnt == FRAME_LAST) begin
          w_state_nxt = ST_IDLE;
          w_timeout   = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Line drives are decoded from the next state so the registered pins line up with r_state.
  always_comb begin
    w_clk_oe_nxt = 1'b0;
    w_dat_oe_nxt = 1'b0;
    case (w_state_nxt)
      ST_INHIBIT: w_clk_oe_nxt = 1'b1;
      ST_REQ: begin
        w_clk_oe_nxt = 1'b1;
        w_dat_oe_nxt = 1'b1;
      end
      ST_XFER: begin
        if (r_state != ST_XFER)               w_dat_oe_nxt = 1'b1;
        else if (w_fall && w_edge_inc <= 4'd9) w_dat_oe_nxt = ~r_frame[w_edge_inc - 4'd1];
        else if (w_fall)                       w_dat_oe_nxt = 1'b0;
        else                                   w_dat_oe_nxt = r_dat_oe;
      end
      default: begin
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_edge_cnt <= 4'd0;
      r_frame    <= 9'd0;
      r_ack_lat  <= 1'b0;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ack_err  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dat_meta <= i_ps2_dat_in;
      r_dat_sync <= r_dat_meta;
      if (w_state_nxt != r_state || w_state_nxt == ST_IDLE) r_cnt <= '0;
      else if (r_state == ST_XFER && w_fall && r_edge_cnt == 4'd0) r_cnt <= '0;
      else r_cnt <= r_cnt + cnt_t'(1);
      if (r_state != ST_XFER) r_edge_cnt <= 4'd0;
      else if (w_fall)        r_edge_cnt <= w_edge_inc;
      if (r_state == ST_IDLE && i_send_valid) r_frame <= {odd_parity(i_send_data), i_send_data};
      if (r_state == ST_XFER && w_fall && r_edge_cnt == LAST_EDGE) r_ack_lat <= r_dat_sync;
      r_clk_oe   <= w_clk_oe_nxt;
      r_dat_oe   <= w_dat_oe_nxt;
      r_ready    <= (w_state_nxt == ST_IDLE);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= w_done;
      r_ack_err  <= w_done & r_ack_lat;
      r_timeout  <= w_timeout;
    end
  end

  assign o_ready      = r_ready;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_ack_err    = r_ack_err;
  assign o_timeout    = r_timeout;
  assign o_ps2_clk_oe = r_clk_oe;
  assign o_ps2_dat_oe = r_dat_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device on wired-AND pins
// clocks frames at a 40-cycle period and samples data on rising clock.
module tb_ps2_host_tx;
  import ps2_defs::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       send_valid;
  logic [7:0] send_data;
  logic       ready, busy, done, ack_err, tmo;
  logic       clk_oe, dat_oe;
  logic       model_clk, model_dat;
  logic       clk_pin, dat_pin;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int tmo_cnt = 0;
  int stray_ack = 0;
  logic done_ack = 1'b0;

  assign clk_pin = model_clk & ~clk_oe;
  assign dat_pin = model_dat & ~dat_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .SETUP_CYCLES   (4),
    .TIMEOUT_START  (400),
    .TIMEOUT_FRAME  (800),
    .FILTER_LEN     (4)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_send_valid (send_valid),
    .i_send_data  (send_data),
    .o_ready      (ready),
    .o_busy       (busy),
    .o_done       (done),
    .o_ack_err    (ack_err),
    .o_timeout    (tmo),
    .i_ps2_clk_in (clk_pin),
    .i_ps2_dat_in (dat_pin),
    .o_ps2_clk_oe (clk_oe),
    .o_ps2_dat_oe (dat_oe)
  );

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_ack <= ack_err;
    end
    if (tmo) tmo_cnt <= tmo_cnt + 1;
    if (ack_err && !done) stray_ack <= stray_ack + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_send(input logic [7:0] data);
    send_valid = 1'b1;
    send_data  = data;
    @(negedge clk);
    send_valid = 1'b0;
  endtask

  // Device side: waits for the clock release, then generates n_falls clock pulses.
  task automatic model_frame(input int n_falls, input int glitch_bit, input bit ack_low,
                             output logic [9:0] cap);
    int w;
    cap = 10'd0;
    w = 0;
    while (clk_oe && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (10) @(negedge clk);
    for (int i = 1; i <= n_falls; i++) begin
      model_clk = 1'b0;
      repeat (20) @(negedge clk);
      model_clk = 1'b1;
      if (i == 11) begin
        repeat (5) @(negedge clk);
        model_dat = 1'b1;
      end else begin
        cap[i-1] = dat_pin;
        if (i == glitch_bit) begin
          repeat (8) @(negedge clk);
          model_clk = 1'b0;
          repeat (2) @(negedge clk);
          model_clk = 1'b1;
          repeat (10) @(negedge clk);
        end else if (i == 10) begin
          repeat (5) @(negedge clk);
          model_dat = ~ack_low;
          repeat (15) @(negedge clk);
        end else begin
          repeat (20) @(negedge clk);
        end
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         glitch_bit;
    bit         ack_low;
    bit         poke_busy;
    logic [9:0] exp_cap;
    logic       exp_ack_err;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cap;
    int n;
    int base_done;
    int base_tmo;

    // exp_cap = {stop, parity, data}; parity = 1 when the byte has an even number of ones.
    vecs[0] = '{CMD_SET_LEDS, 3, 1'b1, 1'b0, 10'h3ED, 1'b0};
    vecs[1] = '{8'h00,        0, 1'b1, 1'b0, 10'h300, 1'b0};
    vecs[2] = '{CMD_ENABLE,   0, 1'b0, 1'b0, 10'h2F4, 1'b1};
    vecs[3] = '{CMD_RESET,    6, 1'b1, 1'b1, 10'h3FF, 1'b0};

    rst = 1'b1;
    send_valid = 1'b0;
    send_data = 8'h00;
    model_clk = 1'b1;
    model_dat = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_dat_oe", dat_oe, 0);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_timeout", tmo, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      base_done = done_cnt;
      base_tmo = tmo_cnt;
      model_clk = 1'b1;
      model_dat = 1'b1;
      start_send(vecs[v].data);
      n = 0;
      while (clk_oe && !dat_oe && n < 100) begin
        if (vecs[v].poke_busy && n == 5) begin
          send_valid = 1'b1;
          send_data = 8'h55;
        end else begin
          send_valid = 1'b0;
        end
        @(negedge clk);
        n++;
      end
      send_valid = 1'b0;
      chk("inhibit_len", n, 20);
      chk("busy_in_req", busy, 1);
      model_frame(11, vecs[v].glitch_bit, vecs[v].ack_low, cap);
      repeat (30) @(negedge clk);
      chk("captured_bits", cap, vecs[v].exp_cap);
      chk("done_pulses", done_cnt - base_done, 1);
      chk("ack_err_at_done", done_ack, vecs[v].exp_ack_err);
      chk("no_timeout", tmo_cnt - base_tmo, 0);
      chk("ready_after", ready, 1);
      chk("lines_released", {clk_oe, dat_oe}, 0);
    end

    // Device never clocks: timeout counted from the clock release.
    base_done = done_cnt;
    base_tmo = tmo_cnt;
    start_send(8'h00);
    n = 0;
    while (clk_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_dat_start_bit", dat_oe, 1);
    n = 0;
    while (!tmo && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", n, 400);
    chk("timeout_oe", {clk_oe, dat_oe}, 0);
    chk("timeout_ready", ready, 1);
    repeat (20) @(negedge clk);
    chk("timeout_no_done", done_cnt - base_done, 0);
    chk("timeout_pulses", tmo_cnt - base_tmo, 1);

    // Reset after fall 5 while bit 4 (a zero) is being driven low.
    base_done = done_cnt;
    start_send(CMD_SET_LEDS);
    model_frame(5, 0, 1'b1, cap);
    chk("partial_bits", cap[4:0], 5'b01101);
    chk("mid_dat_oe", dat_oe, 1);
    chk("mid_ready", ready, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_oe", {clk_oe, dat_oe}, 0);
    chk("async_rst_ready", ready, 1);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_rst_no_done", done_cnt - base_done, 0);
    chk("post_rst_idle", {clk_oe, dat_oe, ready}, 3'b001);
    chk("stray_ack_err", stray_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
